// File: rtl/fb_slave_txbuf_arb_if.sv
// fb_slave_txbuf_arb_if: host/MAC signal bundle for the ping-pong transmit payload buffer.
interface fb_slave_txbuf_arb_if #(parameter int ADDR_W = 4);
    logic              HostWrEn;
    logic [ADDR_W-1:0] HostWrAddr;
    logic [7:0]        HostWrData;
    logic              HostCommit;
    logic              StateIdle;
    logic [1:0]        StateSlaveData;
    logic [7:0]        TxRamAddr;
    logic [7:0]        TxData;
    logic              ActiveBank;
    logic              CommitPending;
    logic [7:0]        SwapCount;
    logic [7:0]        StaleFrames;
    logic              WrDropped;
    logic              AddrErr;
    modport master (
        output HostWrEn, HostWrAddr, HostWrData, HostCommit, StateIdle, StateSlaveData, TxRamAddr,
        input  TxData, ActiveBank, CommitPending, SwapCount, StaleFrames, WrDropped, AddrErr
    );
    modport slave (
        input  HostWrEn, HostWrAddr, HostWrData, HostCommit, StateIdle, StateSlaveData, TxRamAddr,
        output TxData, ActiveBank, CommitPending, SwapCount, StaleFrames, WrDropped, AddrErr
    );
endinterface

// File: rtl/fb_slave_txbuf_arb.sv
// fb_slave_txbuf_arb: ping-pong slave-data payload buffer; the host fills the inactive bank,
// and the active bank only swaps while the MAC is idle so each frame reads one consistent bank.
module fb_slave_txbuf_arb #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input logic MRxClk,
    input logic Reset,
    fb_slave_txbuf_arb_if.slave bus
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [8:0] DEPTH_R = 9'(DEPTH);

    logic [7:0] bank0 [DEPTH];
    logic [7:0] bank1 [DEPTH];
    logic fresh;
    logic prevIdle;
    logic wrOk;
    logic rdOk;
    logic swap;
    logic frameStart;
    logic [IW-1:0] wrIdx;
    logic [IW-1:0] rdIdx;

    assign wrOk = bus.HostWrEn && !bus.CommitPending && ({1'b0, bus.HostWrAddr} < DEPTH_A);
    assign rdOk = {1'b0, bus.TxRamAddr} < DEPTH_R;
    assign wrIdx = bus.HostWrAddr[IW-1:0];
    assign rdIdx = bus.TxRamAddr[IW-1:0];
    assign swap = bus.CommitPending && bus.StateIdle;
    assign frameStart = prevIdle && !bus.StateIdle;
    // The MAC consumes the byte in the same cycle it presents the address.
    assign bus.TxData = !rdOk ? 8'h00 : bus.ActiveBank ? bank1[rdIdx] : bank0[rdIdx];

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank0[i] <= 8'h00;
                bank1[i] <= 8'h00;
            end
        end else if (wrOk) begin
            if (bus.ActiveBank) bank0[wrIdx] <= bus.HostWrData;
            else bank1[wrIdx] <= bus.HostWrData;
        end
    end

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            bus.ActiveBank    <= 1'b0;
            bus.CommitPending <= 1'b0;
            bus.SwapCount     <= 8'h00;
            bus.StaleFrames   <= 8'h00;
            bus.WrDropped     <= 1'b0;
            bus.AddrErr       <= 1'b0;
            fresh             <= 1'b0;
            prevIdle          <= 1'b1;
        end else begin
            prevIdle <= bus.StateIdle;
            if (bus.HostWrEn && !wrOk) bus.WrDropped <= 1'b1;
            if (|bus.StateSlaveData && !rdOk) bus.AddrErr <= 1'b1;
            if (swap) begin
                bus.ActiveBank    <= ~bus.ActiveBank;
                bus.CommitPending <= 1'b0;
                bus.SwapCount     <= bus.SwapCount + 8'd1;
                fresh             <= 1'b1;
            end else if (bus.HostCommit) begin
                bus.CommitPending <= 1'b1;
            end
            // Swap and frame start are exclusive: one needs StateIdle high, the other low.
            if (frameStart) begin
                fresh <= 1'b0;
                if (!fresh && bus.StaleFrames != 8'hFF) bus.StaleFrames <= bus.StaleFrames + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_fb_slave_txbuf_arb.sv
// tb_fb_slave_txbuf_arb: directed scenarios plus randomized traffic checked every cycle
// against a bank/counter model of the ping-pong buffer.
module tb_fb_slave_txbuf_arb;
    localparam int AW = 5;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fb_slave_txbuf_arb_if #(.ADDR_W(AW)) bus ();
    fb_slave_txbuf_arb #(.ADDR_W(AW), .DEPTH(D)) dut (.MRxClk(clk), .Reset(rst), .bus(bus));

    bit [7:0] mb [2][D];
    bit mAct, mPend, mFresh, mPrev, mWd, mAe;
    bit [7:0] mSwaps;
    int mStale;
    int checks = 0;
    int errors = 0;
    logic [7:0] pv [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, got, exp, $time);
        end
    endtask

    function automatic void mReset();
        foreach (mb[b, a]) mb[b][a] = 8'h00;
        mAct = 0; mPend = 0; mFresh = 0; mPrev = 1; mWd = 0; mAe = 0; mSwaps = 0; mStale = 0;
    endfunction

    task automatic cmpAll();
        int ta = int'(bus.TxRamAddr);
        chk("TxData", bus.TxData, ta < D ? mb[mAct][ta] : 8'h00);
        chk("ActiveBank", bus.ActiveBank, mAct);
        chk("CommitPending", bus.CommitPending, mPend);
        chk("SwapCount", bus.SwapCount, mSwaps);
        chk("StaleFrames", bus.StaleFrames, mStale);
        chk("WrDropped", bus.WrDropped, mWd);
        chk("AddrErr", bus.AddrErr, mAe);
    endtask

    function automatic void mStep();
        int wa = int'(bus.HostWrAddr);
        int ta = int'(bus.TxRamAddr);
        bit fs = mPrev && !bus.StateIdle;
        if (bus.HostWrEn && !mPend && wa < D) mb[!mAct][wa] = bus.HostWrData;
        else if (bus.HostWrEn) mWd = 1;
        if (bus.StateSlaveData != 0 && ta >= D) mAe = 1;
        if (mPend && bus.StateIdle) begin
            mAct = !mAct; mPend = 0; mSwaps++; mFresh = 1;
        end else if (bus.HostCommit) mPend = 1;
        if (fs) begin
            if (!mFresh && mStale < 255) mStale++;
            mFresh = 0;
        end
        mPrev = bus.StateIdle;
    endfunction

    task automatic drive(input int we, input int wa, input int wd, input int cm, input int idle, input int ssd, input int ta);
        bus.HostWrEn = we[0];
        bus.HostWrAddr = wa[AW-1:0];
        bus.HostWrData = wd[7:0];
        bus.HostCommit = cm[0];
        bus.StateIdle = idle[0];
        bus.StateSlaveData = ssd[1:0];
        bus.TxRamAddr = ta[7:0];
    endtask

    task automatic cyc(input int we, input int wa, input int wd, input int cm, input int idle, input int ssd, input int ta);
        drive(we, wa, wd, cm, idle, ssd, ta);
        @(negedge clk);
        cmpAll();
        mStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        mReset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            cyc(0, 0, 0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
    endtask

    initial begin
        bit idle;
        rst = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        mReset();
        #12;
        chk("reset_TxData", bus.TxData, 8'h00);
        chk("reset_SwapCount", bus.SwapCount, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) cyc(1, i, int'(pv[i]), 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("pub_pending", bus.CommitPending, 1'b1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        bus.TxRamAddr = 8'd2;
        #1;
        chk("pub_ActiveBank", bus.ActiveBank, 1'b1);
        chk("pub_SwapCount", bus.SwapCount, 8'd1);
        chk("pub_TxData", bus.TxData, 8'hC3);

        cyc(1, 2, 8'h5A, 1, 0, 1, 2);
        repeat (19) cyc(0, 0, 0, 0, 0, 2, 2);
        chk("defer_pending", bus.CommitPending, 1'b1);
        chk("defer_ActiveBank", bus.ActiveBank, 1'b1);
        chk("defer_TxData", bus.TxData, 8'hC3);
        cyc(0, 0, 0, 0, 1, 0, 2);
        chk("defer_swapped", bus.ActiveBank, 1'b0);
        chk("defer_new_TxData", bus.TxData, 8'h5A);

        cyc(0, 0, 0, 1, 0, 0, 3);
        cyc(1, 3, 8'hEE, 0, 0, 0, 3);
        chk("drop_pending_flag", bus.WrDropped, 1'b1);
        cyc(0, 0, 0, 0, 1, 0, 3);
        chk("drop_bank_kept", bus.TxData, 8'hD4);
        doReset();
        cyc(1, D, 8'h77, 0, 1, 0, 0);
        chk("drop_range_flag", bus.WrDropped, 1'b1);
        frames(3);
        chk("drop_sticky", bus.WrDropped, 1'b1);

        doReset();
        frames(3);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        frames(1);
        chk("stale_3", bus.StaleFrames, 8'd3);
        frames(300);
        chk("stale_sat", bus.StaleFrames, 8'd255);

        doReset();
        cyc(0, 0, 0, 0, 0, 0, 8'h20);
        chk("oor_TxData", bus.TxData, 8'h00);
        chk("oor_no_err", bus.AddrErr, 1'b0);
        cyc(0, 0, 0, 0, 0, 1, 8'h20);
        chk("oor_err", bus.AddrErr, 1'b1);

        doReset();
        cyc(1, 0, 8'h99, 0, 1, 0, 0);
        cyc(1, 20, 8'h11, 0, 1, 0, 0);
        frames(2);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("rstp_pending", bus.CommitPending, 1'b1);
        #2 rst = 1'b1;
        mReset();
        #1;
        chk("rstp_CommitPending", bus.CommitPending, 1'b0);
        chk("rstp_ActiveBank", bus.ActiveBank, 1'b0);
        chk("rstp_StaleFrames", bus.StaleFrames, 8'd0);
        chk("rstp_WrDropped", bus.WrDropped, 1'b0);
        chk("rstp_TxData", bus.TxData, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
        chk("rstp_no_swap", bus.ActiveBank, 1'b0);
        chk("rstp_SwapCount", bus.SwapCount, 8'd0);

        doReset();
        idle = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset();
            if ($urandom_range(0, 3) == 0) idle = !idle;
            cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 19)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 7) == 0), int'(idle), idle ? 0 : int'($urandom_range(0, 3)),
                $urandom_range(0, 19) == 0 ? int'($urandom_range(16, 255)) : int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
